// File: rtl/stream_packer32_pkg.sv
// Shared types and constants for the 16-to-32 bit AXI-Stream packer.
package stream_packer32_pkg;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pack_state_t;

    localparam logic [3:0] KEEP_FULL = 4'hF;
    localparam logic [3:0] KEEP_HALF = 4'h3;

    // Entry layout: {last, keep[3:0], data[31:0]}
    localparam int ENTRY_W = 37;

endpackage

// File: rtl/stream_packer32_axis_word_fifo.sv
// First-word-fall-through FIFO for packed output words; full and level are registered.
module axis_word_fifo
    import stream_packer32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [AW:0]      level_nxt;

    assign push_ok = push && !full;
    assign pop_ok  = pop && (level != '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (push_ok && !pop_ok)
            level_nxt = level + 1'b1;
        else if (!push_ok && pop_ok)
            level_nxt = level - 1'b1;
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == LVL_FULL);
        end
    end

endmodule

// File: rtl/stream_packer32.sv
// Packs 16-bit samples into 32-bit AXI-Stream words with TLAST/TKEEP handling,
// output buffering and a sticky overflow flag for beats arriving while full.
module stream_packer32
    import stream_packer32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        overflow,
    input  logic        overflow_clr
);

    localparam int LW = $clog2(DEPTH) + 1;

    pack_state_t        state;
    logic [15:0]        hold;
    logic               fifo_full;
    logic [LW-1:0]      fifo_level;
    logic               accept;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;

    // Ready depends only on the registered full flag, never on m_axis_tready.
    assign s_axis_tready = !fifo_full;
    assign accept        = s_axis_tvalid && !fifo_full;
    assign push          = accept && ((state == HIGH) || s_axis_tlast);
    assign m_axis_tvalid = (fifo_level != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = head;

    always_comb begin
        push_entry = {s_axis_tlast, KEEP_HALF, 16'h0000, s_axis_tdata};
        if (state == HIGH)
            push_entry = {s_axis_tlast, KEEP_FULL, s_axis_tdata, hold};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= LOW;
            hold  <= '0;
        end else if (accept) begin
            case (state)
                LOW: begin
                    if (!s_axis_tlast) begin
                        hold  <= s_axis_tdata;
                        state <= HIGH;
                    end
                end
                HIGH:    state <= LOW;
                default: state <= LOW;
            endcase
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            overflow <= 1'b0;
        else if (s_axis_tvalid && !s_axis_tready)
            overflow <= 1'b1;
        else if (overflow_clr)
            overflow <= 1'b0;
    end

    axis_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (push_entry),
        .pop    (pop),
        .dout   (head),
        .full   (fifo_full),
        .level  (fifo_level)
    );

endmodule

// File: tb/tb_stream_packer32.sv
// Bench for stream_packer32: packet-level reference model plus directed literal checks.
module tb_stream_packer32;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        overflow;
    logic        overflow_clr;

    int total = 0;
    int bad   = 0;

    stream_packer32 #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: words waiting in the output buffer, samples of the
    // unfinished word, and the sticky flag.
    logic [36:0] mq[$];
    logic [15:0] pend[$];
    logic        m_ovf;
    logic [36:0] taken[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            pend.delete();
            m_ovf = 1'b0;
        end else begin
            automatic bit room = (mq.size() < DEPTH);
            automatic bit do_pop = (mq.size() != 0) && m_axis_tready;
            if (s_axis_tvalid && !room)
                m_ovf = 1'b1;
            else if (overflow_clr)
                m_ovf = 1'b0;
            if (do_pop)
                void'(mq.pop_front());
            if (s_axis_tvalid && room) begin
                pend.push_back(s_axis_tdata);
                if (pend.size() == 2) begin
                    mq.push_back({s_axis_tlast, 4'hF, pend[1], pend[0]});
                    pend.delete();
                end else if (s_axis_tlast) begin
                    mq.push_back({1'b1, 4'h3, 16'h0000, pend[0]});
                    pend.delete();
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    logic        prev_stall = 1'b0;
    logic [36:0] prev_word;

    always @(negedge clk) begin
        if (resetn) begin
            automatic logic [36:0] dw = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            chk("tvalid", m_axis_tvalid, mq.size() != 0);
            chk("s_tready", s_axis_tready, mq.size() < DEPTH);
            chk("overflow", overflow, m_ovf);
            if (m_axis_tvalid && mq.size() != 0)
                chk("head_word", dw, mq[0]);
            if (prev_stall && m_axis_tvalid)
                chk("stall_stable", dw, prev_word);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = dw;
            if (m_axis_tvalid && m_axis_tready)
                taken.push_back(dw);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic chk_taken(input string nm, input int idx, input logic [36:0] w);
        if (idx < taken.size())
            chk(nm, taken[idx], w);
        else
            chk({nm, "_missing"}, taken.size(), idx + 1);
    endtask

    initial begin
        resetn        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        overflow_clr  = 1'b0;
        idle(2);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_tkeep", m_axis_tkeep, 4'h0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_s_tready", s_axis_tready, 1'b1);
        resetn = 1'b1;
        idle(2);

        // Even packet and first-word latency
        taken.delete();
        beat(16'h1111, 1'b0);
        chk("lat_before", m_axis_tvalid, 1'b0);
        beat(16'h2222, 1'b0);
        chk("lat_after", m_axis_tvalid, 1'b1);
        beat(16'h3333, 1'b0);
        beat(16'h4444, 1'b1);
        idle(4);
        chk("even_count", taken.size(), 2);
        chk_taken("even_w0", 0, {1'b0, 4'hF, 32'h2222_1111});
        chk_taken("even_w1", 1, {1'b1, 4'hF, 32'h4444_3333});

        // Odd packet
        taken.delete();
        beat(16'h000A, 1'b0);
        beat(16'h000B, 1'b0);
        beat(16'h000C, 1'b1);
        idle(4);
        chk("odd_count", taken.size(), 2);
        chk_taken("odd_w0", 0, {1'b0, 4'hF, 32'h000B_000A});
        chk_taken("odd_w1", 1, {1'b1, 4'h3, 32'h0000_000C});

        // Single-sample packet, then a pair proves the packer stayed in LOW
        taken.delete();
        beat(16'hABCD, 1'b1);
        beat(16'h0001, 1'b0);
        beat(16'h0002, 1'b1);
        idle(4);
        chk("single_count", taken.size(), 2);
        chk_taken("single_w0", 0, {1'b1, 4'h3, 32'h0000_ABCD});
        chk_taken("single_w1", 1, {1'b1, 4'hF, 32'h0002_0001});

        // Backpressure: 8 beats fill four words, beats 9 and 10 are dropped
        taken.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat(16'h0100 + 16'(i), i == 7);
            if (i == 6) chk("bp_ready_7", s_axis_tready, 1'b1);
            if (i == 7) begin
                chk("bp_ready_8", s_axis_tready, 1'b0);
                chk("bp_ovf_8", overflow, 1'b0);
            end
            if (i == 8) chk("bp_ovf_9", overflow, 1'b1);
        end
        m_axis_tready = 1'b1;
        idle(6);
        chk("bp_count", taken.size(), 4);
        chk_taken("bp_w0", 0, {1'b0, 4'hF, 32'h0101_0100});
        chk_taken("bp_w1", 1, {1'b0, 4'hF, 32'h0103_0102});
        chk_taken("bp_w2", 2, {1'b0, 4'hF, 32'h0105_0104});
        chk_taken("bp_w3", 3, {1'b1, 4'hF, 32'h0107_0106});
        chk("bp_ovf_sticky", overflow, 1'b1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("bp_ovf_clr", overflow, 1'b0);

        // Set wins over a simultaneous clear
        taken.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++)
            beat(16'h0300 + 16'(i), i == 7);
        overflow_clr = 1'b1;
        beat(16'hDEAD, 1'b0);
        overflow_clr = 1'b0;
        chk("setwins_ovf", overflow, 1'b1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        m_axis_tready = 1'b1;
        idle(6);
        chk("setwins_clr", overflow, 1'b0);
        chk("setwins_count", taken.size(), 4);
        chk_taken("setwins_w3", 3, {1'b1, 4'hF, 32'h0307_0306});

        // Reset mid-word discards the held half
        taken.delete();
        beat(16'h5555, 1'b0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        beat(16'h6666, 1'b0);
        beat(16'h7777, 1'b1);
        idle(4);
        chk("rst_mid_count", taken.size(), 1);
        chk_taken("rst_mid_w0", 0, {1'b1, 4'hF, 32'h7777_6666});

        // Throttled drain with m_axis_tready toggling every cycle
        taken.delete();
        for (int i = 0; i < 16; i++) begin
            m_axis_tready = i[0];
            beat(16'h0200 + 16'(i), i == 15);
        end
        for (int i = 0; i < 8; i++) begin
            m_axis_tready = i[0];
            step();
        end
        m_axis_tready = 1'b1;
        idle(6);
        chk("thr_count", taken.size(), 8);
        for (int k = 0; k < 8; k++)
            chk_taken("thr_word", k, {k == 7, 4'hF, 16'h0200 + 16'(2*k+1), 16'h0200 + 16'(2*k)});
        chk("thr_ovf", overflow, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_packer32.md
# stream_packer32

Packs the 16-bit XADC sample stream into 32-bit words for the AXI DMA S2MM channel. It sits directly downstream of the TLAST-inserting stage and directly upstream of the DMA. It absorbs DMA backpressure in a small output FIFO and carries TLAST through with correct byte qualification on odd-length packets. The upstream stage ignores `tready`, so the block also records a sticky overflow flag whenever a beat arrives that it cannot accept.

## Interface
- `DEPTH`, default 4: output FIFO depth in 32-bit words; power of two, at least 2.
- `clk` in 1: AXI-Stream clock; all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 16: input sample.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tlast` in 1: last sample of packet.
- `s_axis_tready` out 1: high when the FIFO is not full.
- `m_axis_tdata` out 32: packed word, first sample in [15:0].
- `m_axis_tkeep` out 4: byte qualifiers, 4'hF or 4'h3.
- `m_axis_tvalid` out 1: output word valid.
- `m_axis_tlast` out 1: last word of packet.
- `m_axis_tready` in 1: DMA ready.
- `overflow` out 1: sticky; set on a dropped beat.
- `overflow_clr` in 1: synchronous clear of `overflow`.

## Operation
- An input beat is accepted when `s_axis_tvalid && s_axis_tready`. An output word is taken when `m_axis_tvalid && m_axis_tready`.
- Packer FSM states:
  - **LOW**: waiting for the first half of a word (reset state).
  - **HIGH**: the low half is held in a 16-bit register.
- In LOW, an accepted beat without tlast stores its data in the holding register and moves to HIGH. Nothing is pushed to the FIFO.
- In LOW, an accepted beat with tlast pushes {16'h0000, data} with tkeep 4'h3 and last=1. State stays LOW.
- In HIGH, an accepted beat pushes {data, hold} with tkeep 4'hF and last equal to `s_axis_tlast`, then returns to LOW.
- FIFO entries are 37 bits: data, keep and last. It is first-word-fall-through, and `m_axis_*` is driven directly from the head entry.
- `s_axis_tready = (level != DEPTH)`. The ready signal is uniform in both FSM states, so a low-half beat is also refused when the FIFO is full.
- Overflow:
  - `s_axis_tvalid && !s_axis_tready` sets `overflow` on the next edge. The beat is discarded and the FSM state is unchanged.
  - `overflow_clr` clears the flag. If clear and set occur in the same cycle, set wins.
- A push and a pop in the same cycle leave the level unchanged. This is legal at any level below DEPTH. At DEPTH no push is possible, so a pop simply frees a slot.
- Pointers are log2(DEPTH) bits and wrap naturally. The level counter is log2(DEPTH)+1 bits.
- Reset values:
  - Outputs: `m_axis_tvalid`, `m_axis_tlast`, `overflow` = 0; `m_axis_tdata` = 0; `m_axis_tkeep` = 0; `s_axis_tready` = 1.
  - Internal: FSM = LOW, FIFO empty, holding register = 0.
- Reset mid-packet discards the held low half and every queued word. After release, the next beat is treated as the first sample of a word.

## Timing
- Latency: a beat completing a word at edge N makes `m_axis_tvalid` high in cycle N+1, provided the FIFO was empty.
- Throughput: one input beat per cycle and one output word every two input beats; the DMA can sustain full rate.
- `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` stay stable while `m_axis_tvalid && !m_axis_tready` (AXI-Stream rule).
- `s_axis_tready` is a registered function of the level. A pop in cycle N raises it in cycle N+1, not combinationally.
- There is no combinational path from `m_axis_tready` to `s_axis_tready`.

## Structure
- Shared package holds:
  - the FSM state constants LOW/HIGH;
  - the keep constants KEEP_FULL = 4'hF and KEEP_HALF = 4'h3;
  - the FIFO entry width of 37.
- One natural sub-module: `axis_word_fifo`, a parameterised FWFT FIFO exposing push, pop, full and level. The packer FSM and the overflow logic stay in the top level.

## Test plan
- **Even packet:** send 0x1111, 0x2222, 0x3333, 0x4444 (tlast on 4th) with tready=1 → words 0x2222_1111 (keep F, last 0) and 0x4444_3333 (keep F, last 1); first tvalid one cycle after 0x2222 is accepted.
- **Odd packet:** send 0x000A, 0x000B, 0x000C (tlast on 3rd) → 0x000B_000A (keep F), then 0x0000_000C (keep 3, last 1).
- **Single-sample packet:** 0xABCD with tlast in state LOW → one word 0x0000_ABCD, keep 3, last 1; FSM stays LOW.
- **Backpressure and overflow** (DEPTH=4): hold `m_axis_tready`=0 and send 10 back-to-back beats.
  - Required response: `s_axis_tready` falls after the 4th word is pushed.
  - The 9th beat sets `overflow` and the 10th is also dropped.
  - After tready goes to 1, exactly 4 correct words drain.
  - `overflow` stays 1 until `overflow_clr` is pulsed.
- **Reset mid-word:** accept 0x5555, assert `resetn`=0 for 1 cycle, then send 0x6666, 0x7777 with tlast → single word 0x7777_6666 (keep F, last 1); no word contains 0x5555.
- **Throttled drain:** toggle `m_axis_tready` every cycle while streaming 16 samples → 8 words in order, with data stable on every stalled cycle and no overflow.
